img_reader_pipe: RTL and testbench

Pipelined, parametrised image-window reader for the VGA path. Takes the raster position and sync from the VGA timing generator, places a stored RGB565 image anywhere on screen with integer upscaling (1x/2x/4x), and issues addresses to a synchronous image ROM/RAM. ROM data is converted to 4:4:4 RGB for the VGA port, with sync and DE delayed to match. Sits between the VGA timing controller and the VGA output pins, next to the frame ROM.

---
 rtl/img_reader_pipe.sv | 141 ++++++++++++++
 tb/tb_img_reader_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_reader_pipe.sv
// Pipelined image-window reader: places an RGB565 image on the VGA raster with 1x/2x/4x upscaling.
// Optional 1-pixel white border around the window when IMG_BORDER_EN is defined.
module img_reader_pipe #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int ADDR_W   = 17,
  parameter int ROM_LAT  = 1,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic [9:0]        x0_in,
  input  logic [9:0]        y0_in,
  input  logic [1:0]        scale_in,
  output logic [ADDR_W-1:0] addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int L = ROM_LAT + 2;

  logic [9:0]        x0_q, x0_d, y0_q, y0_d;
  logic [1:0]        scale_q, scale_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [L-1:0]      de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic [L-2:0]      show_pipe_q, show_pipe_d;
  logic [11:0]       rgb_q, rgb_d;
  logic [11:0]       xi, yi, x0w, y0w, span_x, span_y, rel_x, rel_y;
  logic              show;
  logic              unused_rom_bits;

  assign unused_rom_bits = ^{rom_data[11], rom_data[6:5], rom_data[0]};

  // Window geometry is only latched during vertical blanking so it never moves mid-frame.
  always_comb begin
    x0_d    = x0_q;
    y0_d    = y0_q;
    scale_d = scale_q;
    if (!de_in && ({2'b00, y_in} >= 12'(V_ACTIVE))) begin
      x0_d    = x0_in;
      y0_d    = y0_in;
      scale_d = (scale_in == 2'd3) ? 2'd0 : scale_in;
    end
  end

  // 12-bit compares keep x0+span from wrapping at 4x, so oversize windows clip.
  always_comb begin
    xi     = {2'b00, x_in};
    yi     = {2'b00, y_in};
    x0w    = {2'b00, x0_q};
    y0w    = {2'b00, y0_q};
    span_x = 12'(IMG_W) << scale_q;
    span_y = 12'(IMG_H) << scale_q;
    show   = de_in && (xi >= x0w) && (xi < x0w + span_x) &&
             (yi >= y0w) && (yi < y0w + span_y);
    rel_x  = (xi - x0w) >> scale_q;
    rel_y  = (yi - y0w) >> scale_q;
    addr_d = show ? ADDR_W'(24'(rel_y) * 24'(IMG_W) + 24'(rel_x)) : '0;
  end

  always_comb begin
    de_pipe_d   = {de_pipe_q[L-2:0], de_in};
    hs_pipe_d   = {hs_pipe_q[L-2:0], hsync_in};
    vs_pipe_d   = {vs_pipe_q[L-2:0], vsync_in};
    show_pipe_d = {show_pipe_q[L-3:0], show};
  end

`ifdef IMG_BORDER_EN
  logic         border;
  logic [L-2:0] border_pipe_q, border_pipe_d;

  // The ring is the one-pixel-larger rectangle minus the window itself.
  always_comb begin
    border = de_in && !show &&
             (xi + 12'd1 >= x0w) && (xi < x0w + span_x + 12'd1) &&
             (yi + 12'd1 >= y0w) && (yi < y0w + span_y + 12'd1);
    border_pipe_d = {border_pipe_q[L-3:0], border};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) border_pipe_q <= '0;
    else       border_pipe_q <= border_pipe_d;
  end
`endif

  // ROM data arrives one stage before the output register, together with the delayed flags.
  always_comb begin
    rgb_d = 12'h000;
    if (show_pipe_q[L-2]) begin
      rgb_d = {rom_data[15:12], rom_data[10:7], rom_data[4:1]};
    end
`ifdef IMG_BORDER_EN
    else if (border_pipe_q[L-2]) begin
      rgb_d = 12'hFFF;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q        <= '0;
      y0_q        <= '0;
      scale_q     <= '0;
      addr_q      <= '0;
      de_pipe_q   <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
      show_pipe_q <= '0;
      rgb_q       <= '0;
    end else begin
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      scale_q     <= scale_d;
      addr_q      <= addr_d;
      de_pipe_q   <= de_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      show_pipe_q <= show_pipe_d;
      rgb_q       <= rgb_d;
    end
  end

  assign addr      = addr_q;
  assign r_port    = rgb_q[11:8];
  assign g_port    = rgb_q[7:4];
  assign b_port    = rgb_q[3:0];
  assign de_out    = de_pipe_q[L-1];
  assign hsync_out = hs_pipe_q[L-1];
  assign vsync_out = vs_pipe_q[L-1];

endmodule

// File: tb/tb_img_reader_pipe.sv
// Scoreboard bench for img_reader_pipe: two instances (ROM_LAT=1 and ROM_LAT=3) share one stimulus
// stream; expected pixels are queued at drive time and popped when each pipeline delivers them.
module tb_img_reader_pipe;

  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int V_ACTIVE = 480;

  typedef struct {
    logic [31:0] addr;
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } expT;

  logic        clock, reset;
  logic        deIn, hsyncIn, vsyncIn;
  logic [9:0]  xIn, yIn, x0In, y0In;
  logic [1:0]  scaleIn;
  logic [16:0] addr1, addr3;
  logic [15:0] romData1, romData3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        de1, hs1, vs1, de3, hs3, vs3;
  logic [15:0] romPipe1;
  logic [15:0] romPipe3 [3];

  expT qAddr[$];
  expT qOut1[$];
  expT qOut3[$];
  int  modelX0, modelY0, modelScale;
  int  errorCount, checkCount;

  img_reader_pipe #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(17), .ROM_LAT(1), .V_ACTIVE(V_ACTIVE)) dut1 (
    .clk(clock), .reset(reset), .de_in(deIn), .hsync_in(hsyncIn), .vsync_in(vsyncIn),
    .x_in(xIn), .y_in(yIn), .x0_in(x0In), .y0_in(y0In), .scale_in(scaleIn),
    .addr(addr1), .rom_data(romData1), .r_port(r1), .g_port(g1), .b_port(b1),
    .de_out(de1), .hsync_out(hs1), .vsync_out(vs1));

  img_reader_pipe #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(17), .ROM_LAT(3), .V_ACTIVE(V_ACTIVE)) dut3 (
    .clk(clock), .reset(reset), .de_in(deIn), .hsync_in(hsyncIn), .vsync_in(vsyncIn),
    .x_in(xIn), .y_in(yIn), .x0_in(x0In), .y0_in(y0In), .scale_in(scaleIn),
    .addr(addr3), .rom_data(romData3), .r_port(r3), .g_port(g3), .b_port(b3),
    .de_out(de3), .hsync_out(hs3), .vsync_out(vs3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROMs whose content is simply the low 16 address bits.
  always @(posedge clock) begin
    romPipe1    <= addr1[15:0];
    romPipe3[0] <= addr3[15:0];
    romPipe3[1] <= romPipe3[0];
    romPipe3[2] <= romPipe3[1];
  end
  assign romData1 = romPipe1;
  assign romData3 = romPipe3[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference pixel model in plain integer arithmetic.
  function automatic expT model(input int x, input int y, input logic de, input logic hs, input logic vs);
    expT         e;
    int          spanX, spanY;
    bit          show, border;
    logic [15:0] d;
    spanX  = IMG_W << modelScale;
    spanY  = IMG_H << modelScale;
    show   = de && x >= modelX0 && x < modelX0 + spanX && y >= modelY0 && y < modelY0 + spanY;
    border = 1'b0;
`ifdef IMG_BORDER_EN
    border = de && !show && x >= modelX0 - 1 && x <= modelX0 + spanX &&
             y >= modelY0 - 1 && y <= modelY0 + spanY;
`endif
    if (show)
      e.addr = 32'((((y - modelY0) >> modelScale) * IMG_W + ((x - modelX0) >> modelScale)) % (1 << 17));
    else
      e.addr = 32'd0;
    d = e.addr[15:0];
    e.rgb = show ? {d[15:12], d[10:7], d[4:1]} : (border ? 12'hFFF : 12'h000);
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    return e;
  endfunction

  task automatic applyStimulus(input int x, input int y, input logic de, input logic hs, input logic vs);
    expT e, p;
    xIn     = 10'(x);
    yIn     = 10'(y);
    deIn    = de;
    hsyncIn = hs;
    vsyncIn = vs;
    e = model(x, y, de, hs, vs);
    qAddr.push_back(e);
    qOut1.push_back(e);
    qOut3.push_back(e);
    @(posedge clock);
    #1;
    if (!de && y >= V_ACTIVE) begin
      modelX0    = int'(x0In);
      modelY0    = int'(y0In);
      modelScale = (scaleIn == 2'd3) ? 0 : int'(scaleIn);
    end
    if (qAddr.size() >= 1) begin
      p = qAddr.pop_front();
      checkOutput("addr_lat1", 32'(addr1), p.addr);
      checkOutput("addr_lat3", 32'(addr3), p.addr);
    end
    if (qOut1.size() >= 3) begin
      p = qOut1.pop_front();
      checkOutput("rgb_lat1", 32'({r1, g1, b1}), 32'(p.rgb));
      checkOutput("de_lat1", 32'(de1), 32'(p.de));
      checkOutput("hs_lat1", 32'(hs1), 32'(p.hs));
      checkOutput("vs_lat1", 32'(vs1), 32'(p.vs));
    end
    if (qOut3.size() >= 5) begin
      p = qOut3.pop_front();
      checkOutput("rgb_lat3", 32'({r3, g3, b3}), 32'(p.rgb));
      checkOutput("de_lat3", 32'(de3), 32'(p.de));
      checkOutput("hs_lat3", 32'(hs3), 32'(p.hs));
      checkOutput("vs_lat3", 32'(vs3), 32'(p.vs));
    end
  endtask

  // Assert reset between clock edges; every output must drop immediately.
  task automatic doReset();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_addr1", 32'(addr1), 32'd0);
    checkOutput("rst_addr3", 32'(addr3), 32'd0);
    checkOutput("rst_rgb1", 32'({r1, g1, b1}), 32'd0);
    checkOutput("rst_rgb3", 32'({r3, g3, b3}), 32'd0);
    checkOutput("rst_sync1", 32'({de1, hs1, vs1}), 32'd0);
    checkOutput("rst_sync3", 32'({de3, hs3, vs3}), 32'd0);
    qAddr.delete();
    qOut1.delete();
    qOut3.delete();
    modelX0    = 0;
    modelY0    = 0;
    modelScale = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic loadWindow(input int x0, input int y0, input int sc);
    x0In    = 10'(x0);
    y0In    = 10'(y0);
    scaleIn = 2'(sc);
    applyStimulus(0, 490, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int spanX, spanY, x, y;
    errorCount = 0;
    checkCount = 0;
    reset   = 1'b1;
    deIn    = 1'b0;
    hsyncIn = 1'b0;
    vsyncIn = 1'b0;
    xIn     = '0;
    yIn     = '0;
    x0In    = '0;
    y0In    = '0;
    scaleIn = '0;
    modelX0    = 0;
    modelY0    = 0;
    modelScale = 0;
    doReset();

    // Origin window, unit scale.
    loadWindow(0, 0, 0);
    applyStimulus(5, 2, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_5_2", 32'(addr1), 32'd645);
    for (int i = 0; i < 30; i++)
      applyStimulus($urandom_range(0, 639), $urandom_range(0, 479), 1'b1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // 2x window at (100,50), including the far corner and just past it.
    loadWindow(100, 50, 1);
    applyStimulus(101, 51, 1'b1, 1'b1, 1'b0);
    checkOutput("addr_2x_first", 32'(addr1), 32'd0);
    applyStimulus(102, 51, 1'b1, 1'b0, 1'b1);
    checkOutput("addr_2x_second", 32'(addr1), 32'd1);
    applyStimulus(739, 529, 1'b1, 1'b1, 1'b1);
    checkOutput("addr_2x_last", 32'(addr1), 32'd76799);
    applyStimulus(740, 50, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_2x_outside", 32'(addr1), 32'd0);

    // Window hanging off the right edge is clipped, not wrapped.
    loadWindow(500, 0, 0);
    applyStimulus(639, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_clip_639", 32'(addr1), 32'd139);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("addr_clip_col0", 32'(addr1), 32'd0);

    // Config changes during active video must be ignored until blanking.
    loadWindow(0, 0, 0);
    x0In = 10'd200;
    applyStimulus(0, 100, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 500, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 100, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_frozen_x0", 32'(addr1), 32'd32000);
    applyStimulus(0, 480, 1'b0, 1'b0, 1'b1);
    applyStimulus(205, 2, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_new_x0", 32'(addr1), 32'd645);

    // scale_in=3 behaves as 1x.
    loadWindow(0, 0, 3);
    applyStimulus(5, 2, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_scale3", 32'(addr1), 32'd645);

    // Border ring pixels never read the ROM.
    loadWindow(10, 10, 0);
    applyStimulus(9, 10, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_border", 32'(addr1), 32'd0);
    applyStimulus(10, 10, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_win_origin", 32'(addr1), 32'd0);
    applyStimulus(330, 250, 1'b1, 1'b1, 1'b0);
    applyStimulus(11, 9, 1'b1, 1'b0, 1'b1);

    // Random windows with pixels clustered around their edges.
    for (int f = 0; f < 5; f++) begin
      loadWindow($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 3));
      spanX = IMG_W << modelScale;
      spanY = IMG_H << modelScale;
      for (int i = 0; i < 40; i++) begin
        x = modelX0 + $urandom_range(0, spanX + 1) - 1;
        y = modelY0 + $urandom_range(0, spanY + 1) - 1;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        applyStimulus(x, y, 1'($urandom_range(0, 9) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of a line, then resume streaming.
    loadWindow(40, 30, 1);
    for (int i = 0; i < 8; i++)
      applyStimulus(60 + i, 40, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    doReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(i, 3, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 6; i++)
      applyStimulus(0, 500, 1'b0, 1'b0, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
